// File: rtl/io_display_pkg.sv
// Shared definitions for the LED / 7-segment IO peripheral: register offsets,
// blank pattern and the hex-to-segment table (segments active low, bit0 = a).
package io_display_pkg;

  localparam logic [31:0] OFF_RED   = 32'h00;
  localparam logic [31:0] OFF_GREEN = 32'h04;
  localparam logic [31:0] OFF_CTRL  = 32'h08;
  localparam logic [31:0] OFF_DUTY  = 32'h0C;
  localparam logic [31:0] OFF_BLINK = 32'h10;
  localparam logic [31:0] OFF_DIGIT = 32'h20;

  localparam logic [6:0] SEG_BLANK = 7'h7f;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble to active-low 7-segment decoder.
module seg7_decoder
  import io_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end

endmodule

// File: rtl/io_led_display.sv
// Memory-mapped LED / 7-segment output peripheral with PWM brightness and
// registered readback. Optional digit/LED blinking via IO_LED_DISPLAY_BLINK_EN.
module io_led_display
  import io_display_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h00,
  parameter int          RED_WIDTH    = 18,
  parameter int          GREEN_WIDTH  = 9,
  parameter int          NUM_DIGITS   = 4,
  parameter int          PWM_BITS     = 8,
  parameter int          BLINK_DIVIDE = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    io_write_en,
  input  logic                    io_read_en,
  input  logic [31:0]             io_address,
  input  logic [31:0]             io_write_data,
  output logic [31:0]             io_read_data,
  output logic [RED_WIDTH-1:0]    red_led,
  output logic [GREEN_WIDTH-1:0]  green_led,
  output logic [NUM_DIGITS*7-1:0] hex_seg
);

  logic [31:0]             off;
  logic [RED_WIDTH-1:0]    red_q, red_d;
  logic [GREEN_WIDTH-1:0]  green_q, green_d;
  logic [NUM_DIGITS-1:0]   ctrl_q, ctrl_d;
  logic [PWM_BITS:0]       duty_q, duty_d;
  logic [PWM_BITS-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [7:0]              digit_q [NUM_DIGITS];
  logic [7:0]              digit_d [NUM_DIGITS];
  logic [31:0]             rdata_q, rdata_d;
  logic [RED_WIDTH-1:0]    red_out_q, red_out_d;
  logic [GREEN_WIDTH-1:0]  green_out_q, green_out_d;
  logic [NUM_DIGITS*7-1:0] hex_out_q, hex_out_d;
  logic [6:0]              dec_seg [NUM_DIGITS];
  logic                    pwm_on;
  logic [NUM_DIGITS-1:0]   hide_digit;
  logic                    hide_green;
  logic                    hide_red;
  logic                    unused_bits;

  assign off = io_address - BASE_ADDRESS;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decoder u_dec (
      .nibble_i (digit_q[g][3:0]),
      .seg_o    (dec_seg[g])
    );
  end

`ifdef IO_LED_DISPLAY_BLINK_EN
  localparam int BW = $clog2(BLINK_DIVIDE + 1);

  logic [NUM_DIGITS+1:0] blink_mask_q, blink_mask_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;

  always_comb begin
    blink_mask_d  = blink_mask_q;
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (io_write_en && off == OFF_BLINK) blink_mask_d = io_write_data[NUM_DIGITS+1:0];
    if (blink_cnt_q == BW'(BLINK_DIVIDE - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_mask_q  <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      blink_mask_q  <= blink_mask_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign hide_digit  = {NUM_DIGITS{~blink_phase_q}} & blink_mask_q[NUM_DIGITS-1:0];
  assign hide_green  = ~blink_phase_q & blink_mask_q[NUM_DIGITS];
  assign hide_red    = ~blink_phase_q & blink_mask_q[NUM_DIGITS+1];
  assign unused_bits = ^{io_read_en, io_write_data};
`else
  assign hide_digit  = '0;
  assign hide_green  = 1'b0;
  assign hide_red    = 1'b0;
  assign unused_bits = ^{io_read_en, io_write_data, 32'(BLINK_DIVIDE)};
`endif

  // Register writes and the read mux both decode the offset; the read side
  // always sees the pre-write (_q) values, so a same-cycle read returns old data.
  always_comb begin
    red_d     = red_q;
    green_d   = green_q;
    ctrl_d    = ctrl_q;
    duty_d    = duty_q;
    digit_d   = digit_q;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    if (io_write_en) begin
      case (off)
        OFF_RED:   red_d   = io_write_data[RED_WIDTH-1:0];
        OFF_GREEN: green_d = io_write_data[GREEN_WIDTH-1:0];
        OFF_CTRL:  ctrl_d  = io_write_data[NUM_DIGITS-1:0];
        OFF_DUTY:  duty_d  = io_write_data[PWM_BITS:0];
        default: ;
      endcase
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (off == OFF_DIGIT + 32'(4 * i)) digit_d[i] = io_write_data[7:0];
      end
    end

    rdata_d = '0;
    case (off)
      OFF_RED:   rdata_d = 32'(red_q);
      OFF_GREEN: rdata_d = 32'(green_q);
      OFF_CTRL:  rdata_d = 32'(ctrl_q);
      OFF_DUTY:  rdata_d = 32'(duty_q);
`ifdef IO_LED_DISPLAY_BLINK_EN
      OFF_BLINK: rdata_d = 32'(blink_mask_q);
`endif
      default: ;
    endcase
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (off == OFF_DIGIT + 32'(4 * i)) rdata_d = 32'(digit_q[i]);
    end
  end

  assign pwm_on = {1'b0, pwm_cnt_q} < duty_q;

  always_comb begin
    logic [6:0] seg;
    red_out_d   = (pwm_on && !hide_red)   ? red_q   : '0;
    green_out_d = (pwm_on && !hide_green) ? green_q : '0;
    hex_out_d   = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      seg = ctrl_q[i] ? dec_seg[i] : digit_q[i][6:0];
      if (digit_q[i][7] || !pwm_on || hide_digit[i]) seg = SEG_BLANK;
      hex_out_d[7*i +: 7] = seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      red_q       <= '0;
      green_q     <= '0;
      ctrl_q      <= '0;
      duty_q      <= {1'b1, {PWM_BITS{1'b0}}};
      pwm_cnt_q   <= '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 8'h80;
      rdata_q     <= '0;
      red_out_q   <= '0;
      green_out_q <= '0;
      hex_out_q   <= '1;
    end else begin
      red_q       <= red_d;
      green_q     <= green_d;
      ctrl_q      <= ctrl_d;
      duty_q      <= duty_d;
      pwm_cnt_q   <= pwm_cnt_d;
      digit_q     <= digit_d;
      rdata_q     <= rdata_d;
      red_out_q   <= red_out_d;
      green_out_q <= green_out_d;
      hex_out_q   <= hex_out_d;
    end
  end

  assign io_read_data = rdata_q;
  assign red_led      = red_out_q;
  assign green_led    = green_out_q;
  assign hex_seg      = hex_out_q;

endmodule

// File: tb/tb_io_led_display.sv
// Directed bench for io_led_display: reset state, register map, decode modes,
// PWM duty and (when IO_LED_DISPLAY_BLINK_EN is defined) digit blinking.
module tb_io_led_display;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        io_write_en;
  logic        io_read_en;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic [17:0] red_led;
  logic [8:0]  green_led;
  logic [27:0] hex_seg;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  io_led_display #(
    .BASE_ADDRESS (BASE),
    .RED_WIDTH    (18),
    .GREEN_WIDTH  (9),
    .NUM_DIGITS   (4),
    .PWM_BITS     (8),
    .BLINK_DIVIDE (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .red_led       (red_led),
    .green_led     (green_led),
    .hex_seg       (hex_seg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    io_address    = a;
    io_write_data = d;
    io_write_en   = 1'b1;
    @(negedge clk);
    io_write_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    io_address = a;
    io_read_en = 1'b1;
    @(negedge clk);
    io_read_en = 1'b0;
    d = io_read_data;
  endtask

  task automatic settle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_red_on(input int unsigned cycles, output int unsigned on);
    on = 0;
    for (int unsigned c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (red_led != '0) on++;
    end
  endtask

  logic [31:0]  rd;
  int unsigned  on_cnt;
  int unsigned  blank0;
  int unsigned  blank1;

  initial begin
    reset_n       = 1'b0;
    io_write_en   = 1'b0;
    io_read_en    = 1'b0;
    io_address    = '0;
    io_write_data = '0;
    settle(2);
    reset_n = 1'b1;

    check_eq("reset_red",   32'(red_led),   32'h0);
    check_eq("reset_green", 32'(green_led), 32'h0);
    check_eq("reset_hex",   32'(hex_seg),   32'h0FFF_FFFF);
    bus_read(BASE + 32'h0C, rd); check_eq("reset_duty",  rd, 32'h100);
    bus_read(BASE + 32'h08, rd); check_eq("reset_ctrl",  rd, 32'h0);
    bus_read(BASE + 32'h20, rd); check_eq("reset_digit", rd, 32'h80);

    // Raw segment mode and full red write
    bus_write(BASE + 32'h00, 32'h3ffff);
    bus_write(BASE + 32'h20, 32'h05);
    settle(2);
    check_eq("red_full",   32'(red_led), 32'h3ffff);
    check_eq("digit0_raw", 32'(hex_seg), 32'h0FFF_FF85);
    bus_read(BASE + 32'h00, rd); check_eq("read_red", rd, 32'h3ffff);
    bus_write(BASE + 32'h00, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h00, rd); check_eq("red_trunc", rd, 32'h3ffff);

    // Hex decode mode and blank bit
    bus_write(BASE + 32'h08, 32'h1);
    bus_write(BASE + 32'h20, 32'h0A);
    settle(2);
    check_eq("digit0_hexA", 32'(hex_seg[6:0]), 32'h08);
    bus_write(BASE + 32'h20, 32'h8A);
    settle(2);
    check_eq("digit0_blank", 32'(hex_seg[6:0]), 32'h7f);
    bus_write(BASE + 32'h08, 32'hF);
    bus_write(BASE + 32'h28, 32'h07);
    bus_write(BASE + 32'h2C, 32'hF3);
    settle(2);
    check_eq("digit2_hex7", 32'(hex_seg[20:14]), 32'h78);
    check_eq("digit3_blank", 32'(hex_seg[27:21]), 32'h7f);
    bus_read(BASE + 32'h08, rd); check_eq("ctrl_read", rd, 32'hF);

    // Green: readback, write/read collision returns old value
    bus_write(BASE + 32'h04, 32'h155);
    settle(2);
    check_eq("green_out", 32'(green_led), 32'h155);
    io_address    = BASE + 32'h04;
    io_write_data = 32'h0AA;
    io_write_en   = 1'b1;
    io_read_en    = 1'b1;
    @(negedge clk);
    io_write_en = 1'b0;
    io_read_en  = 1'b0;
    check_eq("rw_same_cycle", io_read_data, 32'h155);
    bus_read(BASE + 32'h04, rd); check_eq("green_new", rd, 32'h0AA);

    // Unmapped / out-of-range reads
    bus_read(BASE + 32'h30, rd); check_eq("unmapped_30", rd, 32'h0);
    bus_read(BASE + 32'h14, rd); check_eq("unmapped_14", rd, 32'h0);
    bus_read(32'h0000_0000, rd); check_eq("below_base", rd, 32'h0);
`ifndef IO_LED_DISPLAY_BLINK_EN
    bus_write(BASE + 32'h10, 32'h3F);
    bus_read(BASE + 32'h10, rd); check_eq("blink_absent", rd, 32'h0);
`endif

    // PWM duty
    bus_write(BASE + 32'h0C, 32'h40);
    settle(4);
    count_red_on(256, on_cnt); check_eq("pwm_64", on_cnt, 32'd64);
    bus_write(BASE + 32'h0C, 32'h0);
    settle(4);
    count_red_on(256, on_cnt); check_eq("pwm_0", on_cnt, 32'd0);
    check_eq("pwm0_hex", 32'(hex_seg), 32'h0FFF_FFFF);
    bus_write(BASE + 32'h0C, 32'h1FF);
    settle(4);
    count_red_on(256, on_cnt); check_eq("pwm_full", on_cnt, 32'd256);
    bus_read(BASE + 32'h0C, rd); check_eq("duty_read", rd, 32'h1FF);

`ifdef IO_LED_DISPLAY_BLINK_EN
    bus_write(BASE + 32'h08, 32'h0);
    bus_write(BASE + 32'h20, 32'h05);
    bus_write(BASE + 32'h24, 32'h05);
    bus_write(BASE + 32'h10, 32'h1);
    bus_read(BASE + 32'h10, rd); check_eq("blink_mask", rd, 32'h1);
    settle(4);
    blank0 = 0;
    blank1 = 0;
    for (int unsigned c = 0; c < 16; c++) begin
      @(negedge clk);
      if (hex_seg[6:0] == 7'h7f) blank0++;
      if (hex_seg[13:7] == 7'h7f) blank1++;
    end
    check_eq("blink_digit0", blank0, 32'd8);
    check_eq("blink_digit1", blank1, 32'd0);
`endif

    // Reset mid-run clears all state
    bus_write(BASE + 32'h0C, 32'h40);
    reset_n = 1'b0;
    settle(2);
    reset_n = 1'b1;
    check_eq("rst2_red", 32'(red_led), 32'h0);
    check_eq("rst2_hex", 32'(hex_seg), 32'h0FFF_FFFF);
    bus_read(BASE + 32'h0C, rd); check_eq("rst2_duty", rd, 32'h100);
    bus_read(BASE + 32'h00, rd); check_eq("rst2_red_reg", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
